biss_slave_emu: RTL and testbench

- Emulates a BiSS-C encoder slave: answers master clock (MA) on ssi_sck_i with a serial SLO frame on ssi_dat_o.
- Sits directly upstream of biss_sniffer on the same MA/SLO pair.
- Provides closed-loop stimulus for the sniffer and loopback self-test of the encoder interface.
- Frame: ACK, start, CDS, BITS position bits, nE, nW, inverted CRC6. The sniffer's BITS_CRC=8 covers nE, nW and CRC6.

---
 rtl/biss_slave_emu.sv | 224 ++++++++++++++++++++++
 tb/tb_biss_slave_emu.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biss_slave_emu.sv
// -----------------------------------------------------------------------------
// biss_slave_emu
// BiSS-C encoder slave emulator. Answers the master clock (MA) with a serial
// SLO frame: ACK, start, CDS, BITS position bits (MSB first), nE, nW and an
// inverted CRC6 over the position, nE and nW bits. Frames end when MA stays
// high for TIMEOUT_CLKS clk_i cycles. If MA stops early, the frame is
// aborted instead.
//
// Parameters
//   ACK_LEN       MA rising edges for which SLO is held low as ACK (1..15)
//   TIMEOUT_CLKS  clk_i cycles of continuous MA high that end the timeout or
//                 abort a frame (2..65535)
//
// Ports
//   clk_i      system clock
//   reset_i    asynchronous reset, active low
//   enable_i   1 = respond to MA, 0 = ignore new frames (SLO stays high)
//   BITS       position width. 0 is treated as 1 and >32 as 32
//   posn_i     position value; bits [BITS-1:0] are sent
//   nerr_i     error bit (active low), sent as nE
//   nwarn_i    warning bit (active low), sent as nW
//   ssi_sck_i  MA from the master, idles high, asynchronous to clk_i
//   ssi_dat_o  SLO to the master, idles high
//   busy_o     frame in progress
//   abort_o    one-cycle pulse when a frame is aborted by MA timeout
// -----------------------------------------------------------------------------
module biss_slave_emu #(
   parameter int unsigned ACK_LEN      = 1,
   parameter int unsigned TIMEOUT_CLKS = 250
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic [7:0]  BITS,
   input  logic [31:0] posn_i,
   input  logic        nerr_i,
   input  logic        nwarn_i,
   input  logic        ssi_sck_i,
   output logic        ssi_dat_o,
   output logic        busy_o,
   output logic        abort_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_ACK, S_START, S_CDS, S_DATA, S_NERR, S_NWARN, S_CRC, S_TOUT
   } state_t;

   localparam logic [15:0] TOUT_END = 16'(TIMEOUT_CLKS);
   // The abort decision is taken one count early, so abort_o appears on the
   // same edge at which the counter reaches TIMEOUT_CLKS.
   localparam logic [15:0] ABORT_AT = 16'(TIMEOUT_CLKS - 1);
   localparam logic [5:0]  ACK_LAST = 6'(ACK_LEN - 1);
   localparam logic [5:0]  CRC_POLY = 6'b000011;   // x^6 + x + 1

   logic        sck_meta, sck_sync, sck_prev;
   logic        sck_rise, sck_fall;
   logic [15:0] tout_cnt;
   state_t      state;
   logic [5:0]  bit_cnt;
   logic [5:0]  crc;
   logic [31:0] posn_sh;
   logic        nerr_sh, nwarn_sh;
   logic [5:0]  bits_sh;
   logic [5:0]  bits_clamped;
   logic        tx_bit;
   logic [5:0]  crc_next;

   // MA synchroniser and edge history. Reset to 1 because MA idles high;
   // resetting to 0 would fake a rising edge after reset.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of block order.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sck_meta <= 1'b1;
         sck_sync <= 1'b1;
         sck_prev <= 1'b1;
      end else begin
         sck_meta <= ssi_sck_i;
         sck_sync <= sck_meta;
         sck_prev <= sck_sync;
      end
   end

   assign sck_rise = sck_sync & ~sck_prev;
   assign sck_fall = ~sck_sync & sck_prev;

   // Counts clk_i cycles of continuous (synchronised) MA high; saturates.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         tout_cnt <= '0;
      end else if (!sck_sync) begin
         tout_cnt <= '0;
      end else if (tout_cnt != 16'hFFFF) begin
         tout_cnt <= tout_cnt + 16'd1;
      end
   end

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      bits_clamped = BITS[5:0];
      if (BITS == 8'd0) begin
         bits_clamped = 6'd1;
      end else if (BITS > 8'd32) begin
         bits_clamped = 6'd32;
      end
   end

   // Bit sent on the next MA rising edge in the CRC-covered states.
   always_comb begin
      tx_bit = 1'b0;
      case (state)
         S_DATA:  tx_bit = posn_sh[bit_cnt[4:0]];
         S_NERR:  tx_bit = nerr_sh;
         S_NWARN: tx_bit = nwarn_sh;
         default: tx_bit = 1'b0;
      endcase
   end

   assign crc_next = {crc[4:0], 1'b0} ^ ((tx_bit ^ crc[5]) ? CRC_POLY : 6'b0);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state     <= S_IDLE;
         ssi_dat_o <= 1'b1;
         busy_o    <= 1'b0;
         abort_o   <= 1'b0;
         bit_cnt   <= '0;
         crc       <= '0;
         posn_sh   <= '0;
         nerr_sh   <= 1'b0;
         nwarn_sh  <= 1'b0;
         bits_sh   <= 6'd1;
      end else begin
         abort_o <= 1'b0;
         case (state)
            S_IDLE: begin
               ssi_dat_o <= 1'b1;
               if (sck_fall && enable_i) begin
                  posn_sh  <= posn_i;
                  nerr_sh  <= nerr_i;
                  nwarn_sh <= nwarn_i;
                  bits_sh  <= bits_clamped;
                  crc      <= '0;
                  bit_cnt  <= '0;
                  busy_o   <= 1'b1;
                  state    <= S_ACK;
               end
            end

            // Falling edges here are ignored; only the MA-high timeout ends it.
            S_TOUT: begin
               if (tout_cnt == TOUT_END) begin
                  ssi_dat_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state     <= S_IDLE;
               end else if (sck_rise) begin
                  ssi_dat_o <= 1'b0;
               end
            end

            default: begin
               if (sck_sync && tout_cnt == ABORT_AT) begin
                  ssi_dat_o <= 1'b1;
                  busy_o    <= 1'b0;
                  abort_o   <= 1'b1;
                  state     <= S_IDLE;
               end else if (sck_rise) begin
                  case (state)
                     S_ACK: begin
                        ssi_dat_o <= 1'b0;
                        if (bit_cnt == ACK_LAST) begin
                           bit_cnt <= '0;
                           state   <= S_START;
                        end else begin
                           bit_cnt <= bit_cnt + 6'd1;
                        end
                     end
                     S_START: begin
                        ssi_dat_o <= 1'b1;
                        state     <= S_CDS;
                     end
                     S_CDS: begin
                        ssi_dat_o <= 1'b0;
                        bit_cnt   <= bits_sh - 6'd1;
                        state     <= S_DATA;
                     end
                     S_DATA: begin
                        ssi_dat_o <= tx_bit;
                        crc       <= crc_next;
                        if (bit_cnt == 6'd0) begin
                           state <= S_NERR;
                        end else begin
                           bit_cnt <= bit_cnt - 6'd1;
                        end
                     end
                     S_NERR: begin
                        ssi_dat_o <= tx_bit;
                        crc       <= crc_next;
                        state     <= S_NWARN;
                     end
                     S_NWARN: begin
                        ssi_dat_o <= tx_bit;
                        crc       <= crc_next;
                        bit_cnt   <= 6'd5;
                        state     <= S_CRC;
                     end
                     S_CRC: begin
                        ssi_dat_o <= ~crc[bit_cnt[2:0]];
                        if (bit_cnt == 6'd0) begin
                           state <= S_TOUT;
                        end else begin
                           bit_cnt <= bit_cnt - 6'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_biss_slave_emu.sv
// -----------------------------------------------------------------------------
// tb_biss_slave_emu
// Directed bench for biss_slave_emu. A frame model builds the expected SLO bit
// list when a frame starts (CRC by polynomial long division) and schedules the
// expected output changes at the pin-to-output latency; one compare process
// checks SLO, busy and abort on every clk_i cycle. Literal expectations for
// a few frames pin the model itself.
// -----------------------------------------------------------------------------
module tb_biss_slave_emu;

   localparam int ACK = 1;
   localparam int T   = 60;   // TIMEOUT_CLKS
   localparam int H   = 20;   // MA half period in clk_i cycles

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        enable_i;
   logic [7:0]  BITS;
   logic [31:0] posn_i;
   logic        nerr_i, nwarn_i;
   logic        ssi_sck_i;
   logic        ssi_dat_o, busy_o, abort_o;

   biss_slave_emu #(.ACK_LEN(ACK), .TIMEOUT_CLKS(T)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .enable_i  (enable_i),
      .BITS      (BITS),
      .posn_i    (posn_i),
      .nerr_i    (nerr_i),
      .nwarn_i   (nwarn_i),
      .ssi_sck_i (ssi_sck_i),
      .ssi_dat_o (ssi_dat_o),
      .busy_o    (busy_o),
      .abort_o   (abort_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc++;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   typedef enum {EV_SLO, EV_BUSY, EV_END, EV_ABORT, EV_ABORT_CLR} ev_kind_t;
   typedef struct {
      int       due;
      ev_kind_t kind;
      logic     val;
   } ev_t;

   ev_t  evq[$];
   logic cap_q[$];
   logic frame[$];
   logic exp_slo = 1'b1, exp_busy = 1'b0, exp_abort = 1'b0;
   bit   chk_en = 1'b0;
   bit   m_active = 1'b0;
   int   m_idx = 0;
   int   last_rise = 0;

   function automatic int clamp_bits(input logic [7:0] b);
      if (b == 8'd0) return 1;
      if (b > 8'd32) return 32;
      return int'(b);
   endfunction

   // Remainder of msg(x) * x^6 divided by x^6 + x + 1, MSB first.
   function automatic logic [5:0] crc6_div(input logic msg_in[$]);
      logic       m[$];
      logic [6:0] g;
      logic [5:0] r;
      int         n;
      g = 7'b1000011;
      m = msg_in;
      n = msg_in.size();
      repeat (6) m.push_back(1'b0);
      for (int i = 0; i < n; i++)
         if (m[i])
            for (int j = 0; j < 7; j++) m[i+j] = m[i+j] ^ g[6-j];
      for (int j = 0; j < 6; j++) r[5-j] = m[n+j];
      return r;
   endfunction

   function automatic void build_frame(input logic [31:0] p, input logic [7:0] b,
                                       input logic ne, input logic nw);
      logic       cov[$];
      logic [5:0] c;
      int         n;
      n = clamp_bits(b);
      frame.delete();
      for (int i = 0; i < ACK; i++) frame.push_back(1'b0);
      frame.push_back(1'b1);
      frame.push_back(1'b0);
      for (int i = n - 1; i >= 0; i--) cov.push_back(p[i]);
      cov.push_back(ne);
      cov.push_back(nw);
      foreach (cov[i]) frame.push_back(cov[i]);
      c = crc6_div(cov);
      for (int i = 5; i >= 0; i--) frame.push_back(~c[i]);
   endfunction

   // Compare process: apply due model events, then check every cycle.
   always @(negedge clk_i) begin
      int k;
      k = 0;
      while (k < evq.size()) begin
         if (evq[k].due == cyc) begin
            case (evq[k].kind)
               EV_SLO: begin
                  exp_slo = evq[k].val;
                  cap_q.push_back(ssi_dat_o);
               end
               EV_BUSY:  exp_busy = 1'b1;
               EV_END: begin
                  exp_slo  = 1'b1;
                  exp_busy = 1'b0;
               end
               EV_ABORT: begin
                  exp_slo   = 1'b1;
                  exp_busy  = 1'b0;
                  exp_abort = 1'b1;
               end
               EV_ABORT_CLR: exp_abort = 1'b0;
               default: ;
            endcase
            evq.delete(k);
         end else begin
            k++;
         end
      end
      if (chk_en) begin
         check("slo", ssi_dat_o, exp_slo);
         check("busy", busy_o, exp_busy);
         check("abort", abort_o, exp_abort);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic ma_fall();
      @(negedge clk_i);
      ssi_sck_i = 1'b0;
      if (!m_active && enable_i) begin
         build_frame(posn_i, BITS, nerr_i, nwarn_i);
         m_active = 1'b1;
         m_idx    = 0;
         evq.push_back('{cyc + 3, EV_BUSY, 1'b1});
      end
      tick(H - 1);
   endtask

   task automatic ma_rise();
      logic v;
      @(negedge clk_i);
      ssi_sck_i = 1'b1;
      last_rise = cyc;
      if (m_active) begin
         v = (m_idx < frame.size()) ? frame[m_idx] : 1'b0;
         m_idx++;
         evq.push_back('{cyc + 3, EV_SLO, v});
      end
      tick(H - 1);
   endtask

   task automatic ma_burst(input int n);
      repeat (n) begin
         ma_fall();
         ma_rise();
      end
   endtask

   // Hold MA high past the timeout; report when SLO returned high and when/how
   // often abort_o pulsed, counted from the last MA rising edge on the pin.
   task automatic ma_hold(output int slo_dly, output int ab_dly, output int ab_cnt);
      int lim;
      slo_dly = -1;
      ab_dly  = -1;
      ab_cnt  = 0;
      if (m_active) begin
         if (m_idx >= frame.size()) begin
            evq.push_back('{last_rise + T + 3, EV_END, 1'b1});
         end else begin
            evq.push_back('{last_rise + T + 2, EV_ABORT, 1'b1});
            evq.push_back('{last_rise + T + 3, EV_ABORT_CLR, 1'b0});
         end
         m_active = 1'b0;
      end
      lim = last_rise + T + 8;
      while (cyc < lim) begin
         @(negedge clk_i);
         if (slo_dly < 0 && ssi_dat_o === 1'b1) slo_dly = cyc - last_rise;
         if (abort_o === 1'b1) begin
            ab_cnt++;
            if (ab_dly < 0) ab_dly = cyc - last_rise;
         end
      end
   endtask

   function automatic logic [31:0] cap_slice(input int first, input int n);
      logic [31:0] v;
      v = '0;
      for (int i = first; i < first + n; i++)
         v = {v[30:0], (i < cap_q.size()) ? cap_q[i] : 1'bx};
      return v;
   endfunction

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   sd, ad, ac;
      logic q3[$];

      reset_i   = 1'b0;
      ssi_sck_i = 1'b1;
      enable_i  = 1'b1;
      BITS      = 8'd1;
      posn_i    = 32'd1;
      nerr_i    = 1'b1;
      nwarn_i   = 1'b1;
      tick(3);
      check("reset_slo", ssi_dat_o, 1'b1);
      check("reset_busy", busy_o, 1'b0);
      check("reset_abort", abort_o, 1'b0);
      reset_i = 1'b1;
      chk_en  = 1'b1;
      tick(5);

      // Model pin: CRC of {1,1,1} is 001001.
      q3 = '{1'b1, 1'b1, 1'b1};
      check("model_crc", crc6_div(q3), 6'b001001);

      // BITS=1, posn=1, nE=nW=1: literal frame and timeout latency.
      cap_q.delete();
      ma_burst(12);
      ma_hold(sd, ad, ac);
      check("t1_len", cap_q.size(), 12);
      check("t1_frame", cap_slice(0, 12), 32'b0101_1111_0110);
      check("t1_tout_dly", sd, T + 3);
      check("t1_no_abort", ac, 0);

      // BITS=32 full frame.
      BITS   = 8'd32;
      posn_i = 32'hA5A5_0F0F;
      cap_q.delete();
      ma_burst(43);
      ma_hold(sd, ad, ac);
      check("t2_data", cap_slice(3, 32), 32'hA5A5_0F0F);
      check("t2_no_abort", ac, 0);

      // Abort after 10 rising edges, then a full frame with nE=0.
      ma_burst(10);
      ma_hold(sd, ad, ac);
      check("abort_dly", ad, T + 2);
      check("abort_cnt", ac, 1);
      check("abort_slo", ssi_dat_o, 1'b1);
      check("abort_busy", busy_o, 1'b0);
      nerr_i = 1'b0;
      posn_i = 32'h0F0F_A5A5;
      cap_q.delete();
      ma_burst(43);
      ma_hold(sd, ad, ac);
      check("post_abort_data", cap_slice(3, 32), 32'h0F0F_A5A5);
      check("post_abort_ne", cap_q[35], 1'b0);
      nerr_i = 1'b1;

      // Disabled: no frame at all.
      enable_i = 1'b0;
      ma_burst(43);
      ma_hold(sd, ad, ac);
      enable_i = 1'b1;

      // enable_i dropped mid-frame: the frame completes.
      posn_i = 32'hDEAD_BEEF;
      cap_q.delete();
      ma_burst(5);
      enable_i = 1'b0;
      ma_burst(38);
      ma_hold(sd, ad, ac);
      check("en_drop_data", cap_slice(3, 32), 32'hDEAD_BEEF);
      enable_i = 1'b1;

      // Inputs changed after the latching edge.
      BITS   = 8'd8;
      posn_i = 32'd5;
      nwarn_i = 1'b0;
      cap_q.delete();
      ma_fall();
      posn_i  = 32'd7;
      BITS    = 8'd16;
      nwarn_i = 1'b1;
      ma_rise();
      ma_burst(18);
      ma_hold(sd, ad, ac);
      check("latch_data", cap_slice(3, 8), 32'h05);
      check("latch_nw", cap_q[12], 1'b0);

      // BITS=0 -> one data bit; BITS=40 -> 32 data bits.
      BITS   = 8'd0;
      posn_i = 32'hFFFF_FFFE;
      cap_q.delete();
      ma_burst(12);
      ma_hold(sd, ad, ac);
      check("bits0_data", cap_q[3], 1'b0);
      check("bits0_no_abort", ac, 0);
      BITS   = 8'd40;
      posn_i = 32'h8000_0001;
      cap_q.delete();
      ma_burst(43);
      ma_hold(sd, ad, ac);
      check("bits40_data", cap_slice(3, 32), 32'h8000_0001);
      check("bits40_no_abort", ac, 0);

      // Async reset in the middle of the data field.
      BITS   = 8'd32;
      posn_i = 32'h1234_5678;
      ma_burst(15);
      @(posedge clk_i);
      #2;
      evq.delete();
      exp_slo   = 1'b1;
      exp_busy  = 1'b0;
      exp_abort = 1'b0;
      m_active  = 1'b0;
      reset_i   = 1'b0;
      #1;
      check("async_rst_slo", ssi_dat_o, 1'b1);
      check("async_rst_busy", busy_o, 1'b0);
      tick(3);
      reset_i = 1'b1;
      tick(5);
      cap_q.delete();
      ma_burst(43);
      ma_hold(sd, ad, ac);
      check("post_rst_data", cap_slice(3, 32), 32'h1234_5678);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
